// File: rtl/idct_mul_phase_sequencer_if.sv
// Handshake and control bundle between the block controller and the IDCT multiplier phase sequencer.
// The controller drives the master side, and the sequencer uses the slave side.
interface idct_mul_phase_sequencer_if #(
    parameter int CNT_W = 9
);
    logic             start;
    logic             abort;
    logic             stall;
    logic             apx_row;
    logic             apx_col;
    logic [2:0]       state_out;
    logic [CNT_W-1:0] count0;
    logic             rapx;
    logic             acc_sel;
    logic             mac_en;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, stall, apx_row, apx_col,
        input  state_out, count0, rapx, acc_sel, mac_en, busy, done
    );

    modport slave (
        input  start, abort, stall, apx_row, apx_col,
        output state_out, count0, rapx, acc_sel, mac_en, busy, done
    );
endinterface

// File: rtl/idct_mul_phase_sequencer.sv
// Phase/count sequencer for the shared IDCT multiplier: ROW -> XFER -> COL -> DRAIN per start.
// Phase and count are registered. done is a registered pulse. mac_en and the precision selects decode the registered state.
module idct_mul_phase_sequencer #(
    parameter int ROW_LEN   = 64,
    parameter int XFER_LEN  = 8,
    parameter int COL_LEN   = 64,
    parameter int DRAIN_LEN = 8,
    parameter int CNT_W     = 9
) (
    input  logic                        clk,
    input  logic                        rstP,
    idct_mul_phase_sequencer_if.slave   sq
);
    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_ROW   = 3'b001;
    localparam logic [2:0] S_XFER  = 3'b010;
    localparam logic [2:0] S_COL   = 3'b011;
    localparam logic [2:0] S_DRAIN = 3'b100;

    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_LEN - 1);
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_LEN - 1);
    localparam logic [CNT_W-1:0] COL_LAST   = CNT_W'(COL_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);

    logic [2:0]       phase_q, phase_d, next_phase;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             apx_row_q, apx_col_q;
    logic             done_q, done_d;
    logic             last_cnt;
    logic             busy_w, rapx_w;

    always_comb begin
        last_cnt   = 1'b0;
        next_phase = S_IDLE;
        case (phase_q)
            S_ROW:   begin last_cnt = (cnt_q == ROW_LAST);   next_phase = S_XFER;  end
            S_XFER:  begin last_cnt = (cnt_q == XFER_LAST);  next_phase = S_COL;   end
            S_COL:   begin last_cnt = (cnt_q == COL_LAST);   next_phase = S_DRAIN; end
            S_DRAIN: begin last_cnt = (cnt_q == DRAIN_LAST); next_phase = S_IDLE;  end
            default: begin last_cnt = 1'b0;                  next_phase = S_IDLE;  end
        endcase
    end

    // abort outranks stall, and stall outranks the count/advance path
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (phase_q)
            S_IDLE: begin
                cnt_d = '0;
                if (sq.start) begin
                    phase_d = S_ROW;
                end
            end
            S_ROW, S_XFER, S_COL, S_DRAIN: begin
                if (sq.abort) begin
                    phase_d = S_IDLE;
                    cnt_d   = '0;
                end else if (!sq.stall) begin
                    if (last_cnt) begin
                        phase_d = next_phase;
                        cnt_d   = '0;
                        done_d  = (phase_q == S_DRAIN);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                phase_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstP) begin
            phase_q   <= S_IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            apx_row_q <= 1'b0;
            apx_col_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (phase_q == S_IDLE && sq.start) begin
                apx_row_q <= sq.apx_row;
                apx_col_q <= sq.apx_col;
            end
        end
    end

    always_comb begin
        rapx_w = 1'b0;
        case (phase_q)
            S_ROW, S_XFER:  rapx_w = apx_row_q;
            S_COL, S_DRAIN: rapx_w = apx_col_q;
            default:        rapx_w = 1'b0;
        endcase
    end

    assign busy_w       = (phase_q != S_IDLE);
    assign sq.state_out = phase_q;
    assign sq.count0    = cnt_q;
    assign sq.busy      = busy_w;
    assign sq.done      = done_q;
    assign sq.rapx      = rapx_w;
    assign sq.acc_sel   = busy_w & ~rapx_w;
    assign sq.mac_en    = ((phase_q == S_ROW) || (phase_q == S_COL)) & ~sq.stall;
endmodule

// File: tb/tb_idct_mul_phase_sequencer.sv
// Directed, table-driven bench for idct_mul_phase_sequencer with hand-computed phase timelines.
module tb_idct_mul_phase_sequencer;
    localparam int CNT_W = 9;

    logic clk = 1'b0;
    logic rstP;

    idct_mul_phase_sequencer_if #(.CNT_W(CNT_W)) sq ();

    idct_mul_phase_sequencer #(
        .ROW_LEN(64), .XFER_LEN(8), .COL_LEN(64), .DRAIN_LEN(8), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rstP(rstP),
        .sq  (sq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int st;
        int cnt;
        int rapx;
        int acc;
        int mac;
        int busy;
        int done;
    } vec_t;

    vec_t main_tab[10];
    vec_t zero_v;
    int   vecs   = 0;
    int   miscmp = 0;
    int   n      = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            miscmp++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t v);
        chk($sformatf("%s@%0d.state", tag, n), int'(sq.state_out), v.st);
        chk($sformatf("%s@%0d.count0", tag, n), int'(sq.count0), v.cnt);
        chk($sformatf("%s@%0d.rapx", tag, n), int'(sq.rapx), v.rapx);
        chk($sformatf("%s@%0d.acc_sel", tag, n), int'(sq.acc_sel), v.acc);
        chk($sformatf("%s@%0d.mac_en", tag, n), int'(sq.mac_en), v.mac);
        chk($sformatf("%s@%0d.busy", tag, n), int'(sq.busy), v.busy);
        chk($sformatf("%s@%0d.done", tag, n), int'(sq.done), v.done);
    endtask

    task automatic step();
        @(negedge clk);
        n++;
    endtask

    // start is sampled at the next edge; cycle n then shows the state after n edges
    task automatic start_block(input logic ar, input logic ac);
        sq.start   = 1'b1;
        sq.apx_row = ar;
        sq.apx_col = ac;
        n = 0;
        step();
        sq.start = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    task automatic wait_done(input int limit, output int at);
        at = -1;
        while (n < limit) begin
            if (sq.done) begin
                at = n;
                break;
            end
            step();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_row, n_xfer, n_col, n_drain, n_done, at, nd, extra;
        int d[3];

        zero_v = '{default: 0};
        //             cyc  st cnt rapx acc mac busy done
        main_tab[0] = '{  1, 1,  0, 1, 0, 1, 1, 0};
        main_tab[1] = '{ 64, 1, 63, 1, 0, 1, 1, 0};
        main_tab[2] = '{ 65, 2,  0, 1, 0, 0, 1, 0};
        main_tab[3] = '{ 72, 2,  7, 1, 0, 0, 1, 0};
        main_tab[4] = '{ 73, 3,  0, 0, 1, 1, 1, 0};
        main_tab[5] = '{136, 3, 63, 0, 1, 1, 1, 0};
        main_tab[6] = '{137, 4,  0, 0, 1, 0, 1, 0};
        main_tab[7] = '{144, 4,  7, 0, 1, 0, 1, 0};
        main_tab[8] = '{145, 0,  0, 0, 0, 0, 0, 1};
        main_tab[9] = '{146, 0,  0, 0, 0, 0, 0, 0};

        // reset, with start and stall held to show reset wins
        rstP       = 1'b1;
        sq.start   = 1'b1;
        sq.abort   = 1'b0;
        sq.stall   = 1'b1;
        sq.apx_row = 1'b1;
        sq.apx_col = 1'b1;
        repeat (3) step();
        chk_outs("reset", zero_v);
        rstP     = 1'b0;
        sq.start = 1'b0;
        sq.stall = 1'b0;
        step();

        // full block, apx_row=1 apx_col=0; a start with new modes is injected during DRAIN
        n_row = 0; n_xfer = 0; n_col = 0; n_drain = 0; n_done = 0;
        start_block(1'b1, 1'b0);
        for (int c = 1; c <= 146; c++) begin
            case (sq.state_out)
                3'b001:  n_row++;
                3'b010:  n_xfer++;
                3'b011:  n_col++;
                3'b100:  n_drain++;
                default: ;
            endcase
            if (sq.done) n_done++;
            foreach (main_tab[i]) begin
                if (main_tab[i].cyc == c) chk_outs("main", main_tab[i]);
            end
            sq.start = (c == 140);
            if (c == 140) begin
                sq.apx_row = 1'b1;
                sq.apx_col = 1'b1;
            end
            if (c < 146) step();
        end
        chk("main.row_cycles", n_row, 64);
        chk("main.xfer_cycles", n_xfer, 8);
        chk("main.col_cycles", n_col, 64);
        chk("main.drain_cycles", n_drain, 8);
        chk("main.done_pulses", n_done, 1);

        // five stalled cycles at ROW count0=30
        start_block(1'b0, 1'b1);
        run_to(31);
        chk("stall.pre_count", int'(sq.count0), 30);
        for (int i = 0; i < 5; i++) begin
            sq.stall = 1'b1;
            #1;
            chk($sformatf("stall.count[%0d]", i), int'(sq.count0), 30);
            chk($sformatf("stall.mac_en[%0d]", i), int'(sq.mac_en), 0);
            chk($sformatf("stall.state[%0d]", i), int'(sq.state_out), 1);
            step();
        end
        sq.stall = 1'b0;
        #1;
        chk("stall.post_count", int'(sq.count0), 30);
        chk("stall.post_mac_en", int'(sq.mac_en), 1);
        wait_done(400, at);
        chk("stall.done_cycle", at, 150);
        step();

        // abort at COL count0=10 (stall also high), then restart on the next cycle
        start_block(1'b0, 1'b0);
        run_to(83);
        chk("abort.pre_state", int'(sq.state_out), 3);
        chk("abort.pre_count", int'(sq.count0), 10);
        sq.abort = 1'b1;
        sq.stall = 1'b1;
        step();
        chk_outs("abort", zero_v);
        sq.abort = 1'b0;
        sq.stall = 1'b0;
        start_block(1'b1, 1'b1);
        chk("abort.restart_rapx", int'(sq.rapx), 1);
        chk("abort.restart_acc_sel", int'(sq.acc_sel), 0);
        wait_done(400, at);
        chk("abort.restart_done_cycle", at, 145);
        step();

        // start held high: done every 145 cycles, IDLE only on done cycles
        d = '{-1, -1, -1};
        nd = 0;
        extra = 0;
        sq.start   = 1'b1;
        sq.apx_row = 1'b0;
        sq.apx_col = 1'b0;
        n = 0;
        while (nd < 3 && n < 500) begin
            step();
            if (sq.done) begin
                if (sq.state_out != 3'b000) extra++;
                d[nd] = n;
                nd++;
            end else if (sq.state_out == 3'b000) begin
                extra++;
            end
        end
        sq.start = 1'b0;
        chk("b2b.done_count", nd, 3);
        chk("b2b.done0", d[0], 145);
        chk("b2b.done1", d[1], 290);
        chk("b2b.done2", d[2], 435);
        chk("b2b.stray_idle", extra, 0);
        step();

        // reset at XFER count0=3 with start asserted alongside
        start_block(1'b1, 1'b0);
        run_to(68);
        chk("rst.pre_state", int'(sq.state_out), 2);
        chk("rst.pre_count", int'(sq.count0), 3);
        chk("rst.pre_rapx", int'(sq.rapx), 1);
        rstP     = 1'b1;
        sq.start = 1'b1;
        sq.stall = 1'b1;
        step();
        sq.stall = 1'b0;
        #1;
        chk_outs("rst", zero_v);
        rstP     = 1'b0;
        sq.start = 1'b0;
        step();
        chk("rst.after_state", int'(sq.state_out), 0);
        step();

        // illegal phase code injected during ROW returns to IDLE
        start_block(1'b0, 1'b0);
        run_to(10);
        chk("illegal.pre_count", int'(sq.count0), 9);
        force dut.phase_q = 3'b110;
        #1;
        release dut.phase_q;
        step();
        chk("illegal.state", int'(sq.state_out), 0);
        chk("illegal.count0", int'(sq.count0), 0);
        chk("illegal.busy", int'(sq.busy), 0);
        chk("illegal.done", int'(sq.done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end
endmodule

// File: doc/idct_mul_phase_sequencer.md
Name: idct_mul_phase_sequencer

Overview:
- Sequencer for the shared IDCT multiplier wrapper.
- Generates the 3-bit phase code, the 9-bit `count0` index, and the precision controls `rapx` and `acc_sel` that the wrapper consumes.
- Runs one 8x8 block per `start`: row pass, transfer, column pass, drain. Handshakes with the block-level controller via `start`/`busy`/`done`/`abort`.
- Supports a per-cycle stall from downstream.

Parameters:
- ROW_LEN, 64, cycles spent in the row phase (001).
- XFER_LEN, 8, cycles spent in the transfer/rescale phase (010).
- COL_LEN, 64, cycles spent in the column phase (011).
- DRAIN_LEN, 8, cycles spent in the drain phase (100).
- CNT_W, 9, width of `count0`. Every *_LEN must be ≤ 2^CNT_W and ≥ 1.

Ports:
- clk  in  1  single clock, rising edge.
- rstP  in  1  synchronous, active-high reset.
- start  in  1  begin one block; sampled only in IDLE.
- abort  in  1  synchronous return to IDLE, no `done`.
- stall  in  1  freeze phase and counter this cycle.
- apx_row  in  1  approximate mode for phases 001/010; latched at start.
- apx_col  in  1  approximate mode for phases 011/100; latched at start.
- state_out  out  3  phase code to wrapper `state_in_to_wrapper`.
- count0  out  CNT_W  cycle index within the current phase.
- rapx  out  1  approximate-bit reset/select to wrapper.
- acc_sel  out  1  selects the accurate product path in wrapper.
- mac_en  out  1  a multiply is issued this cycle.
- busy  out  1  high in any non-IDLE phase.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: when `rstP` is high at a clock edge, all outputs go to 0 next cycle: state_out=000, count0=0, rapx=0, acc_sel=0, mac_en=0, busy=0, done=0. Latched mode bits also go to 0. `rstP` has priority over `abort`, `stall` and `start`.
- Phases and codes:
  - IDLE=000, ROW=001, XFER=010, COL=011, DRAIN=100.
  - Codes 101–111 are illegal. If reached, the next cycle is IDLE with count0=0.
- Start:
  - In IDLE with `start`=1, latch `apx_row` and `apx_col`; next cycle state_out=001, count0=0.
  - `start` is ignored outside IDLE.
  - `stall` does not block acceptance of `start` in IDLE.
- Counting, in non-IDLE phases with `stall`=0:
  - If count0 == LEN(phase)-1, advance to the next phase and clear count0 to 0.
  - Otherwise count0 increments by 1.
  - Phase order: ROW→XFER→COL→DRAIN→IDLE.
- Stall: in a non-IDLE phase with `stall`=1, state_out and count0 hold and mac_en=0. `stall` has no effect in IDLE.
- mac_en = busy & ~stall, and only in ROW or COL. mac_en is 0 in XFER, DRAIN and IDLE.
- Precision outputs (combinational from registered state and latched modes):
  - rapx = latched apx_row in ROW/XFER; latched apx_col in COL/DRAIN; 0 in IDLE.
  - acc_sel = busy & ~rapx.
- done:
  - Registered. High for exactly the one cycle in which state_out first returns to 000 after a DRAIN phase completes normally. 0 otherwise.
  - A `start` sampled in that same cycle is accepted (back-to-back blocks allowed). The new block's ROW begins the following cycle.
- Abort: in any non-IDLE phase, `abort`=1 at an edge sends the block to IDLE next cycle with count0=0 and done=0. `abort` takes priority over `stall` and phase advance. `abort` in IDLE is a no-op and does not block `start`; if both are high in IDLE, `start` wins.
- Latency: with no stall, `start` sampled at edge k gives state_out=001 from k+1. The final DRAIN cycle is at k+144 with default lengths, and done=1 at k+145. Each stalled cycle adds exactly one cycle.
- Wrapper contract: in ROW, count0 reaches ROW_LEN-1 (63) exactly once per block, one cycle before XFER. The wrapper's load condition keys on this.
- mid-operation `rstP`: the block discards all state, with no done pulse.

Test Plan:
- Reset, then `start`=1 for 1 cycle with apx_row=1, apx_col=0, no stall:
  - state_out sequence 001×64, 010×8, 011×64, 100×8, then 000.
  - count0 wraps 63→0 and 7→0 at the phase boundaries.
  - rapx=1 / acc_sel=0 for the first 72 cycles, then rapx=0 / acc_sel=1.
  - done=1 exactly at cycle 145 after start.
- Stall: `stall` high for 5 cycles at ROW count0=30 → count0 holds at 30, mac_en=0 for those 5 cycles, and done is delayed to cycle 150.
- Abort: `abort` at COL count0=10 → IDLE next cycle, done never asserts, busy=0. Then `start` in the following cycle → a full block completes.
- Back-to-back: `start` held high continuously → done pulses every 145 cycles and state_out returns to 000 only during the done cycle.
- Reset mid-run: `rstP` at XFER count0=3 → all outputs are 0 next cycle. A `start` asserted with `rstP` in the same cycle is ignored.
- Ignored and illegal cases:
  - `start` asserted during DRAIN → no effect on phase sequence, counter or latched modes.
  - Force-inject state code 110 (bench back-door) → IDLE next cycle.
